// File: rtl/neuron_cfg_sequencer_if.sv
// neuron_cfg_sequencer_if: valid/ready word stream from the input pads
// into the configuration sequencer.
interface neuron_cfg_sequencer_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/neuron_cfg_sequencer.sv
// neuron_cfg_sequencer: parses the serial config stream into neuron-array
// writes plus the annealing mu schedule, and arbitrates host readouts.
module neuron_cfg_sequencer #(
    parameter int FP_DATA_WIDTH = 16,
    parameter int TEN_DATA_WIDTH = 2,
    parameter int NUM_NEURON = 512,
    parameter int NEURON_ID_WIDTH = 9,
    parameter logic [FP_DATA_WIDTH-1:0] SYNC_WORD = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       reset_l,
    neuron_cfg_sequencer_if.slave      word_if,
    output logic                       cfg_wr_en,
    output logic [1:0]                 cfg_field,
    output logic [NEURON_ID_WIDTH-1:0] cfg_neuron_id,
    output logic [NEURON_ID_WIDTH-1:0] cfg_q_addr,
    output logic [FP_DATA_WIDTH-1:0]   cfg_data,
    output logic                       mu_upd,
    output logic [FP_DATA_WIDTH-1:0]   mu_data,
    output logic                       anneal_run,
    input  logic                       rd,
    output logic                       read_start,
    input  logic                       read_ack,
    output logic                       readDone,
    output logic                       seq_done,
    output logic                       cfg_err
);

    localparam int CW = $clog2(NUM_NEURON + 1);
    localparam logic [FP_DATA_WIDTH-1:0] MAX_N = FP_DATA_WIDTH'(NUM_NEURON);
    localparam logic [1:0] F_VMEM = 2'd0;
    localparam logic [1:0] F_MU   = 2'd1;
    localparam logic [1:0] F_Q    = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_VMEM,
        S_MU,
        S_ID,
        S_WR_V,
        S_WR_M,
        S_QROW,
        S_MUHDR,
        S_MUSTR,
        S_DONE,
        S_ERR,
        S_RD_WAIT
    } state_t;

    state_t state;
    state_t state_nx;
    state_t saved;

    logic                       started;
    logic                       rd_pend;
    logic [CW-1:0]              n_cnt;
    logic [CW-1:0]              col;
    logic [CW-1:0]              rec;
    logic [FP_DATA_WIDTH-1:0]   m_len;
    logic [FP_DATA_WIDTH-1:0]   mu_cnt;
    logic [FP_DATA_WIDTH-1:0]   vmem_buf;
    logic [FP_DATA_WIDTH-1:0]   mu_buf;
    logic [NEURON_ID_WIDTH-1:0] id_reg;

    logic [FP_DATA_WIDTH-1:0] word;
    logic accept;
    logic svc_ok;
    logic ready_st;
    logic svc;
    logic col_last;
    logic rec_last;
    logic mu_last;

    logic                       wr_en_d;
    logic [1:0]                 field_d;
    logic [NEURON_ID_WIDTH-1:0] id_d;
    logic [NEURON_ID_WIDTH-1:0] qaddr_d;
    logic [FP_DATA_WIDTH-1:0]   data_d;
    logic                       mu_upd_d;
    logic [FP_DATA_WIDTH-1:0]   mu_data_d;
    logic                       anneal_d;
    logic                       read_start_d;
    logic                       read_done_d;
    logic                       seq_done_d;
    logic                       err_d;

    assign word     = word_if.in_data;
    assign accept   = word_if.in_valid && word_if.in_ready;
    assign col_last = (col == n_cnt - CW'(1));
    assign rec_last = (rec == n_cnt - CW'(1));
    assign mu_last  = (mu_cnt == m_len - FP_DATA_WIDTH'(1));

    // Readouts may only interrupt states where the stream is at a word
    // boundary and no buffered record write is in flight.
    assign svc_ok = (state == S_QROW) || (state == S_MUHDR) ||
                    (state == S_MUSTR) || (state == S_DONE);
    assign svc    = started && rd_pend && svc_ok;

    assign ready_st = (state == S_IDLE) || (state == S_SYNC) ||
                      (state == S_VMEM) || (state == S_MU) ||
                      (state == S_ID) || (state == S_QROW) ||
                      (state == S_MUHDR) || (state == S_MUSTR) ||
                      (state == S_ERR);

    assign word_if.in_ready = started && ready_st && !svc;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (svc) begin
            state_nx = S_RD_WAIT;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    state_nx = (word == '0 || word > MAX_N) ? S_ERR : S_SYNC;
                end
                S_SYNC: if (accept) begin
                    state_nx = (word != SYNC_WORD) ? S_ERR : S_VMEM;
                end
                S_VMEM: if (accept) state_nx = S_MU;
                S_MU:   if (accept) state_nx = S_ID;
                S_ID: if (accept) begin
                    state_nx = (word >= MAX_N) ? S_ERR : S_WR_V;
                end
                S_WR_V: state_nx = S_WR_M;
                S_WR_M: state_nx = S_QROW;
                S_QROW: if (accept && col_last) begin
                    state_nx = rec_last ? S_MUHDR : S_VMEM;
                end
                S_MUHDR: if (accept) begin
                    state_nx = (word == '0) ? S_DONE : S_MUSTR;
                end
                S_MUSTR: if (accept && mu_last) state_nx = S_DONE;
                S_RD_WAIT: if (read_ack) state_nx = saved;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        wr_en_d      = 1'b0;
        field_d      = cfg_field;
        id_d         = cfg_neuron_id;
        qaddr_d      = cfg_q_addr;
        data_d       = cfg_data;
        mu_upd_d     = 1'b0;
        mu_data_d    = mu_data;
        anneal_d     = anneal_run;
        read_start_d = svc;
        read_done_d  = 1'b0;
        if (state == S_ID && accept && word < MAX_N) begin
            wr_en_d = 1'b1;
            field_d = F_VMEM;
            id_d    = word[NEURON_ID_WIDTH-1:0];
            qaddr_d = '0;
            data_d  = vmem_buf;
        end
        if (state == S_WR_V) begin
            wr_en_d = 1'b1;
            field_d = F_MU;
            id_d    = id_reg;
            qaddr_d = '0;
            data_d  = mu_buf;
        end
        if (state == S_QROW && accept) begin
            wr_en_d = 1'b1;
            field_d = F_Q;
            id_d    = id_reg;
            qaddr_d = col[NEURON_ID_WIDTH-1:0];
            data_d  = {{(FP_DATA_WIDTH-TEN_DATA_WIDTH){1'b0}},
                       word[TEN_DATA_WIDTH-1:0]};
        end
        if (state == S_MUSTR && accept) begin
            mu_upd_d  = 1'b1;
            mu_data_d = word;
            anneal_d  = 1'b1;
        end
        if (state_nx == S_DONE) anneal_d = 1'b0;
        if (state == S_RD_WAIT && read_ack) read_done_d = 1'b1;
        // A request in ERR is acknowledged without touching the readout unit.
        if (state == S_ERR && (rd || rd_pend)) read_done_d = 1'b1;
        seq_done_d = seq_done || (state_nx == S_DONE);
        err_d      = cfg_err || (state_nx == S_ERR);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cfg_wr_en     <= 1'b0;
            cfg_field     <= '0;
            cfg_neuron_id <= '0;
            cfg_q_addr    <= '0;
            cfg_data      <= '0;
            mu_upd        <= 1'b0;
            mu_data       <= '0;
            anneal_run    <= 1'b0;
            read_start    <= 1'b0;
            readDone      <= 1'b0;
            seq_done      <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            cfg_wr_en     <= wr_en_d;
            cfg_field     <= field_d;
            cfg_neuron_id <= id_d;
            cfg_q_addr    <= qaddr_d;
            cfg_data      <= data_d;
            mu_upd        <= mu_upd_d;
            mu_data       <= mu_data_d;
            anneal_run    <= anneal_d;
            read_start    <= read_start_d;
            readDone      <= read_done_d;
            seq_done      <= seq_done_d;
            cfg_err       <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            started  <= 1'b0;
            rd_pend  <= 1'b0;
            saved    <= S_IDLE;
            n_cnt    <= '0;
            col      <= '0;
            rec      <= '0;
            m_len    <= '0;
            mu_cnt   <= '0;
            vmem_buf <= '0;
            mu_buf   <= '0;
            id_reg   <= '0;
        end else begin
            started <= 1'b1;
            // A fresh rd wins over the ack clear so it is not lost.
            if (state == S_ERR) begin
                rd_pend <= 1'b0;
            end else if (rd) begin
                rd_pend <= 1'b1;
            end else if (state == S_RD_WAIT && read_ack) begin
                rd_pend <= 1'b0;
            end
            if (svc) saved <= state;
            if (accept) begin
                unique case (state)
                    S_IDLE: begin
                        n_cnt <= word[CW-1:0];
                        col   <= '0;
                        rec   <= '0;
                    end
                    S_VMEM: vmem_buf <= word;
                    S_MU:   mu_buf <= word;
                    S_ID: begin
                        id_reg <= word[NEURON_ID_WIDTH-1:0];
                        col    <= '0;
                    end
                    S_QROW: begin
                        if (col_last) begin
                            col <= '0;
                            rec <= rec + CW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    S_MUHDR: begin
                        m_len  <= word;
                        mu_cnt <= '0;
                    end
                    S_MUSTR: mu_cnt <= mu_cnt + FP_DATA_WIDTH'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule
